// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Produces column/row counters plus sync, active-video and start-of-line/frame
// strobes for a parameterised video mode. Every output is a flop whose D input
// is decoded from the next counter values. That keeps the strobes aligned with
// column/row, and lets them come out of reset without glitches.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic             hsync,
  output logic             vsync,
  output logic             rgb_en,
  output logic [CNT_W-1:0] column,
  output logic [CNT_W-1:0] row,
  output logic             line_start,
  output logic             frame_start
);

  // Line and frame totals, resolved at elaboration.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter wrap points.
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Region boundaries are held one bit wider than the counters. A boundary
  // can equal 2^CNT_W when a total exactly fills the counter range, and the
  // extra bit keeps that case from wrapping.
  localparam int EW = CNT_W + 1;
  localparam logic [EW-1:0] H_ACT_END   = EW'(H_ACTIVE);
  localparam logic [EW-1:0] H_SYNC_BEG  = EW'(H_ACTIVE + H_FP);
  localparam logic [EW-1:0] H_SYNC_END  = EW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [EW-1:0] V_ACT_END   = EW'(V_ACTIVE);
  localparam logic [EW-1:0] V_SYNC_BEG  = EW'(V_ACTIVE + V_FP);
  localparam logic [EW-1:0] V_SYNC_END  = EW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] col_reg, col_next;
  logic [CNT_W-1:0] row_reg, row_next;
  logic             hsync_reg, hsync_next;
  logic             vsync_reg, vsync_next;
  logic             rgb_en_reg, rgb_en_next;
  logic             line_start_reg, line_start_next;
  logic             frame_start_reg, frame_start_next;

  logic [EW-1:0]    col_ext;
  logic [EW-1:0]    row_ext;
  logic             h_active;
  logic             v_active;
  logic             h_sync_zone;
  logic             v_sync_zone;

  // Next-count logic: advance one pixel per enabled edge and wrap at the totals.
  // The row moves only on a horizontal wrap.
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (pix_en) begin
      if (col_reg == H_LAST) begin
        col_next = '0;
        if (row_reg == V_LAST) begin
          row_next = '0;
        end else begin
          row_next = row_reg + 1'b1;
        end
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  // Region decode on the next counts. With pix_en low the next counts equal
  // the current ones, so every decoded output holds its value.
  always_comb begin
    col_ext          = {1'b0, col_next};
    row_ext          = {1'b0, row_next};
    h_active         = (col_ext < H_ACT_END);
    v_active         = (row_ext < V_ACT_END);
    h_sync_zone      = (col_ext >= H_SYNC_BEG) && (col_ext < H_SYNC_END);
    v_sync_zone      = (row_ext >= V_SYNC_BEG) && (row_ext < V_SYNC_END);
    hsync_next       = h_sync_zone ? HSYNC_POL : ~HSYNC_POL;
    vsync_next       = v_sync_zone ? VSYNC_POL : ~VSYNC_POL;
    rgb_en_next      = h_active && v_active;
    line_start_next  = (col_next == '0);
    frame_start_next = (col_next == '0) && (row_next == '0);
  end

  // State and output registers. Reset loads the decode of position 0/0, so
  // release produces no edge on any output until counting actually starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg         <= '0;
      row_reg         <= '0;
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      rgb_en_reg      <= 1'b1;
      line_start_reg  <= 1'b1;
      frame_start_reg <= 1'b1;
    end else begin
      col_reg         <= col_next;
      row_reg         <= row_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      rgb_en_reg      <= rgb_en_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign column      = col_reg;
  assign row         = row_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign rgb_en      = rgb_en_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Instance A runs the default 640x480 mode.
// Instance B runs a tiny mode (H 8/2/2/2, V 4/1/1/1, HSYNC_POL=1) so that
// whole frames and vertical wraps fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, rst_b, en_b;
  logic        hs_a, vs_a, rgb_a, ls_a, fs_a;
  logic [10:0] col_a, row_a;
  logic        hs_b, vs_b, rgb_b, ls_b, fs_b;
  logic [3:0]  col_b, row_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pix_en(en_a),
    .hsync(hs_a), .vsync(vs_a), .rgb_en(rgb_a),
    .column(col_a), .row(row_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_en(en_b),
    .hsync(hs_b), .vsync(vs_b), .rgb_en(rgb_b),
    .column(col_b), .row(row_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int tests = 0;
  int fails = 0;
  int ea_col, ea_row, eb_col, eb_row;
  int fs_count, max_row;
  logic [3:0] pat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference position of instance A (800 x 525).
  task automatic adv_a(input logic en);
    if (en) begin
      if (ea_col == 799) begin
        ea_col = 0;
        ea_row = (ea_row == 524) ? 0 : ea_row + 1;
      end else begin
        ea_col = ea_col + 1;
      end
    end
  endtask

  // Reference position of instance B (14 x 7).
  task automatic adv_b();
    if (eb_col == 13) begin
      eb_col = 0;
      eb_row = (eb_row == 6) ? 0 : eb_row + 1;
    end else begin
      eb_col = eb_col + 1;
    end
  endtask

  task automatic chk_a(input string tag);
    check({tag, ".col"}, 32'(col_a), 32'(ea_col));
    check({tag, ".row"}, 32'(row_a), 32'(ea_row));
    check({tag, ".hs"},  32'(hs_a),  32'(!(ea_col >= 656 && ea_col <= 751)));
    check({tag, ".vs"},  32'(vs_a),  32'(!(ea_row >= 490 && ea_row <= 491)));
    check({tag, ".rgb"}, 32'(rgb_a), 32'(ea_col < 640 && ea_row < 480));
    check({tag, ".ls"},  32'(ls_a),  32'(ea_col == 0));
    check({tag, ".fs"},  32'(fs_a),  32'(ea_col == 0 && ea_row == 0));
  endtask

  task automatic chk_b(input string tag);
    check({tag, ".col"}, 32'(col_b), 32'(eb_col));
    check({tag, ".row"}, 32'(row_b), 32'(eb_row));
    check({tag, ".hs"},  32'(hs_b),  32'(eb_col == 10 || eb_col == 11));
    check({tag, ".vs"},  32'(vs_b),  32'(eb_row != 5));
    check({tag, ".rgb"}, 32'(rgb_b), 32'(eb_col < 8 && eb_row < 4));
    check({tag, ".ls"},  32'(ls_b),  32'(eb_col == 0));
    check({tag, ".fs"},  32'(fs_b),  32'(eb_col == 0 && eb_row == 0));
  endtask

  task automatic chk_reset_a(input string tag);
    check({tag, ".col"}, 32'(col_a), 32'd0);
    check({tag, ".row"}, 32'(row_a), 32'd0);
    check({tag, ".hs"},  32'(hs_a),  32'd1);
    check({tag, ".vs"},  32'(vs_a),  32'd1);
    check({tag, ".rgb"}, 32'(rgb_a), 32'd1);
    check({tag, ".ls"},  32'(ls_a),  32'd1);
    check({tag, ".fs"},  32'(fs_a),  32'd1);
  endtask

  task automatic chk_reset_b(input string tag);
    check({tag, ".col"}, 32'(col_b), 32'd0);
    check({tag, ".row"}, 32'(row_b), 32'd0);
    check({tag, ".hs"},  32'(hs_b),  32'd0);
    check({tag, ".vs"},  32'(vs_b),  32'd1);
    check({tag, ".rgb"}, 32'(rgb_b), 32'd1);
    check({tag, ".ls"},  32'(ls_b),  32'd1);
    check({tag, ".fs"},  32'(fs_b),  32'd1);
  endtask

  initial begin
    rst_a = 1'b0; en_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b1;

    // Reset state of both instances, held over several clocks.
    repeat (3) tick();
    chk_reset_a("a_rst");
    chk_reset_b("b_rst");

    // First enabled edge after release moves the column to 1.
    rst_a = 1'b1;
    tick();
    ea_col = 1; ea_row = 0;
    check("a_rel_col1", 32'(col_a), 32'd1);
    chk_a("a_rel");

    // Rest of line 0 and the wrap into line 1.
    for (int i = 0; i < 799; i++) begin
      tick();
      adv_a(1'b1);
      chk_a("a_line");
    end
    check("a_wrap_col", 32'(col_a), 32'd0);
    check("a_wrap_row", 32'(row_a), 32'd1);
    check("a_wrap_ls",  32'(ls_a),  32'd1);

    // Enable pattern 1,0,0,1: the count moves only on enabled edges.
    pat = 4'b1001;
    for (int k = 0; k < 12; k++) begin
      en_a = pat[3 - (k % 4)];
      tick();
      adv_a(en_a);
      chk_a("a_en");
    end
    en_a = 1'b1;
    check("a_en_col", 32'(col_a), 32'd6);

    // Move into the active region of line 1, then reset asynchronously.
    for (int i = 0; i < 50; i++) begin
      tick();
      adv_a(1'b1);
      chk_a("a_run");
    end
    #3 rst_a = 1'b0;
    #1 chk_reset_a("a_async");
    tick();
    chk_reset_a("a_hold");
    rst_a = 1'b1;
    tick();
    ea_col = 1; ea_row = 0;
    chk_a("a_restart");

    // Instance B: two full frames, counting frame_start pulses and the row range.
    rst_b = 1'b1;
    tick();
    eb_col = 1; eb_row = 0;
    chk_b("b_rel");
    fs_count = 0; max_row = 0;
    for (int i = 0; i < 196; i++) begin
      tick();
      adv_b();
      chk_b("b_frame");
      if (fs_b === 1'b1) fs_count++;
      if (int'(row_b) > max_row) max_row = int'(row_b);
    end
    check("b_fs_count", 32'(fs_count), 32'd2);
    check("b_max_row",  32'(max_row),  32'd6);

    // Run to row 3, column 6, then reset mid-frame.
    for (int i = 0; i < 47; i++) begin
      tick();
      adv_b();
      chk_b("b_run");
    end
    check("b_pos_col", 32'(col_b), 32'd6);
    check("b_pos_row", 32'(row_b), 32'd3);
    #3 rst_b = 1'b0;
    #1 chk_reset_b("b_async");
    tick();
    rst_b = 1'b1;
    tick();
    eb_col = 1; eb_row = 0;
    chk_b("b_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 H_ACTIVE, 640, visible pixels per line, SHALL be a parameter.
REQ-002 H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porch/sync lengths in pixels, SHALL be parameters.
REQ-003 V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical lengths in lines, SHALL be parameters.
REQ-004 HSYNC_POL, 0; VSYNC_POL, 0: asserted sync level (0 = active-low), SHALL be parameters.
REQ-005 CNT_W, 11, width of column/row counters, SHALL be a parameter; each total must be <= 2^CNT_W.
REQ-006 clk  in  1  pixel-domain clock; single clock domain.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 pix_en  in  1  pixel-advance enable; counters move only on a clk rising edge with pix_en=1.
REQ-009 hsync  out  1  horizontal sync at HSYNC_POL when asserted.
REQ-010 vsync  out  1  vertical sync at VSYNC_POL when asserted.
REQ-011 rgb_en  out  1  high when the current pixel is in both the horizontal and vertical active regions.
REQ-012 column  out  CNT_W  current horizontal count, 0..H_TOTAL-1.
REQ-013 row  out  CNT_W  current vertical count, 0..V_TOTAL-1.
REQ-014 line_start  out  1  one-pixel pulse when column=0.
REQ-015 frame_start  out  1  one-pixel pulse when column=0 and row=0.

Function
REQ-016 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise; both computed at elaboration.
REQ-017 Line order SHALL be active, front porch, sync, back porch; column 0 is the first visible pixel.
REQ-018 On each enabled edge column SHALL increment; column=H_TOTAL-1 SHALL wrap to 0 and advance row by one.
REQ-019 Row SHALL advance only at the horizontal wrap; row=V_TOTAL-1 at horizontal wrap SHALL wrap to 0.
REQ-020 With pix_en=0 all outputs SHALL hold their values, pulses included.
REQ-021 hsync SHALL be asserted iff H_ACTIVE+H_FP <= column < H_ACTIVE+H_FP+H_SYNC.
REQ-022 vsync SHALL be asserted iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, for the full length of those lines.
REQ-023 rgb_en SHALL be 1 iff column < H_ACTIVE and row < V_ACTIVE.
REQ-024 All outputs SHALL be registered; hsync, vsync, rgb_en, line_start and frame_start SHALL be aligned with column/row (zero skew), decoded from next-count values.
REQ-025 Counter arithmetic SHALL be unsigned CNT_W-bit; no count value >= total SHALL ever appear on column or row.
REQ-026 Each state persists per enabled pixel; the pixel rate equals the clk rate times the pix_en duty.

Reset
REQ-027 While rst=0: column=0, row=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, rgb_en=1, line_start=1, frame_start=1, asynchronously.
REQ-028 Reset assertion mid-line or mid-frame SHALL abandon the current frame; after release, the first enabled edge SHALL move column to 1.
REQ-029 Reset release SHALL be glitch-free on all outputs; no spurious sync pulse SHALL be produced.

Verification
REQ-030 Defaults, pix_en=1, rst pulse low then high: column=0, row=0, hsync=1, vsync=1, rgb_en=1 during reset; column=1 one cycle after release.
REQ-031 Run 800 enabled cycles: hsync=0 exactly for column 656..751; rgb_en=0 for column 640..799; column 799 -> 0 with row 0 -> 1 and line_start=1.
REQ-032 Run a full frame of 420000 cycles: vsync=0 exactly for rows 490..491; frame_start pulses once per frame, at column=0, row=0.
REQ-033 Toggle pix_en 1,0,0,1 repeatedly: column advances only on enabled edges; all outputs are stable across disabled edges.
REQ-034 Assert rst at row 300, column 500: outputs return to the REQ-027 values immediately without waiting for clk; counting restarts from 0/0.
REQ-035 Override parameters to H 8,2,2,2 / V 4,1,1,1 with HSYNC_POL=1: hsync=1 only at column 10..11; row wraps after 7 lines; no out-of-range counts appear.
